// File: rtl/pipe_reg_elastic.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pipe_reg_elastic
// Description : Two-entry elastic pipeline register (MAIN + SKID) with
//               valid/ready handshaking, flush, bubble forcing on the control
//               bundle and saturating stall/bubble statistics counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_reg_elastic #(
  parameter int DATA_W = 32,
  parameter int N_DATA = 6,
  parameter int CTRL_W = 17,
  parameter int CNT_W  = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CTRL_W-1:0]        in_ctrl,
  input  logic [N_DATA*DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CTRL_W-1:0]        out_ctrl,
  output logic [N_DATA*DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]         stall_cnt,
  output logic [CNT_W-1:0]         bubble_cnt
);

  localparam int              c_PAYLOAD_W = N_DATA * DATA_W;
  localparam logic [1:0]      c_EMPTY     = 2'd0;
  localparam logic [1:0]      c_ONE       = 2'd1;
  localparam logic [1:0]      c_TWO       = 2'd2;
  localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

  logic [1:0]             r_state;
  logic [1:0]             w_nextState;
  logic                   r_inReady;
  logic [CTRL_W-1:0]      r_mainCtrl;
  logic [c_PAYLOAD_W-1:0] r_mainData;
  logic [CTRL_W-1:0]      r_skidCtrl;
  logic [c_PAYLOAD_W-1:0] r_skidData;
  logic [CNT_W-1:0]       r_stallCnt;
  logic [CNT_W-1:0]       r_bubbleCnt;

  logic w_mainValid;
  logic w_xferIn;
  logic w_xferOut;
  logic w_loadMainIn;
  logic w_loadMainSkid;
  logic w_loadSkid;

  // MAIN is occupied in ONE and TWO; a flush cycle never accepts new input.
  assign w_mainValid = (r_state == c_ONE) || (r_state == c_TWO);
  assign w_xferIn    = in_valid & r_inReady & ~flush;
  assign w_xferOut   = w_mainValid & out_ready;

  // State register; in_ready is registered from the next state so it is glitch-free.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= c_EMPTY;
      r_inReady <= 1'b1;
    end else begin
      r_state   <= w_nextState;
      r_inReady <= (w_nextState != c_TWO);
    end
  end

  // Next-state and entry-load selection; flush wins over every transfer.
  always_comb begin
    w_nextState    = r_state;
    w_loadMainIn   = 1'b0;
    w_loadMainSkid = 1'b0;
    w_loadSkid     = 1'b0;
    case (r_state)
      c_EMPTY: begin
        if (w_xferIn) begin
          w_nextState  = c_ONE;
          w_loadMainIn = 1'b1;
        end
      end
      c_ONE: begin
        if (w_xferIn && w_xferOut) begin
          w_loadMainIn = 1'b1;
        end else if (w_xferIn) begin
          w_nextState = c_TWO;
          w_loadSkid  = 1'b1;
        end else if (w_xferOut) begin
          w_nextState = c_EMPTY;
        end
      end
      c_TWO: begin
        if (w_xferOut) begin
          w_nextState    = c_ONE;
          w_loadMainSkid = 1'b1;
        end
      end
      default: w_nextState = c_EMPTY;
    endcase
    if (flush) begin
      w_nextState    = c_EMPTY;
      w_loadMainIn   = 1'b0;
      w_loadMainSkid = 1'b0;
      w_loadSkid     = 1'b0;
    end
  end

  // Outputs come straight from MAIN; control is forced to zero on a bubble.
  always_comb begin
    in_ready   = r_inReady;
    out_valid  = w_mainValid;
    out_ctrl   = w_mainValid ? r_mainCtrl : '0;
    out_data   = r_mainData;
    stall_cnt  = r_stallCnt;
    bubble_cnt = r_bubbleCnt;
  end

  // Entry storage; MAIN is only rewritten on a load so held outputs stay stable.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mainCtrl <= '0;
      r_mainData <= '0;
      r_skidCtrl <= '0;
      r_skidData <= '0;
    end else begin
      if (w_loadMainIn) begin
        r_mainCtrl <= in_ctrl;
        r_mainData <= in_data;
      end else if (w_loadMainSkid) begin
        r_mainCtrl <= r_skidCtrl;
        r_mainData <= r_skidData;
      end
      if (w_loadSkid) begin
        r_skidCtrl <= in_ctrl;
        r_skidData <= in_data;
      end
    end
  end

  // Saturating statistics on the pre-edge handshake; flush cycles still count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_stallCnt  <= '0;
      r_bubbleCnt <= '0;
    end else begin
      if (w_mainValid && !out_ready && (r_stallCnt != c_CNT_MAX)) begin
        r_stallCnt <= r_stallCnt + c_CNT_ONE;
      end
      if (!w_mainValid && out_ready && (r_bubbleCnt != c_CNT_MAX)) begin
        r_bubbleCnt <= r_bubbleCnt + c_CNT_ONE;
      end
    end
  end

endmodule
`default_nettype wire
